riscv_conv_tile_dma: RTL

Memory-side streamer for the convolution unit in the EX stage. Fetches a 4x4 input tile of 32-bit words from data memory and pushes it, word by word with its index, into the convolution unit's tile registers. Also writes the unit's four 2x2 results back to memory. Sits between the convolution unit and the core's data-memory request/grant/rvalid port, sharing that port with the LSU through the existing arbiter.

---
 rtl/riscv_defines.sv | 18 +
 rtl/riscv_conv_addr_gen.sv | 35 +++
 rtl/riscv_conv_tile_dma.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the convolution tile streamer and its address generator.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package riscv_defines;

    // Tile streamer command sequencing
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } conv_dma_state_t;

    localparam int CONV_TILE_WORDS = 16;
    localparam int CONV_RES_WORDS  = 4;
    localparam int CONV_TILE_DIM   = 4;

endpackage

// File: rtl/riscv_conv_addr_gen.sv
// Word address for element cnt of a 4x4 input tile (load) or a 2x2 result block (store).
// Latency: purely combinational.
// Backpressure: none; the caller holds its inputs stable while a request is pending.
module riscv_conv_addr_gen
    import riscv_defines::*;
(
    input  logic        mode_i,
    input  logic [31:0] base_i,
    input  logic [31:0] stride_i,
    input  logic [4:0]  cnt_i,
    output logic [31:0] addr_o
);

    logic [31:0] cnt_w;
    logic [31:0] row;
    logic [31:0] col;

    assign cnt_w = {27'b0, cnt_i};

    // Split the linear index into row/column; results form a 2x2 block, tiles a 4x4 one.
    // Everything wraps modulo 2^32 and only the low 32 bits of the product are kept.
    always_comb begin
        row = '0;
        col = '0;
        if (mode_i) begin
            row = cnt_w >> 1;
            col = cnt_w & 32'd1;
        end else begin
            row = cnt_w / 32'(CONV_TILE_DIM);
            col = cnt_w % 32'(CONV_TILE_DIM);
        end
        addr_o = (base_i & 32'hFFFF_FFFC) + row * stride_i + (col << 2);
    end

endmodule

// File: rtl/riscv_conv_tile_dma.sv
// Streams a 4x4 tile from data memory into the conv unit, or writes its 2x2 results back.
// Latency: one request per word, one outstanding; each load word reaches the conv unit one cycle after rvalid.
// Backpressure: address/data held in REQ until data_gnt_i; WAIT holds until data_rvalid_i, no timeout.
module riscv_conv_tile_dma
    import riscv_defines::*;
#(
    parameter int TILE_WORDS = CONV_TILE_WORDS,
    parameter int RES_WORDS  = CONV_RES_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] stride_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        tile_wr_o,
    output logic [3:0]  tile_idx_o,
    output logic [31:0] tile_data_o,
    output logic [1:0]  res_idx_o,
    input  logic [31:0] res_data_i
);

    conv_dma_state_t state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [31:0]     base_q, base_d;
    logic [31:0]     stride_q, stride_d;
    logic            tile_wr_q, tile_wr_d;
    logic [3:0]      tile_idx_q, tile_idx_d;
    logic [31:0]     tile_data_q, tile_data_d;
    logic [4:0]      last_idx;

    assign last_idx = mode_q ? 5'(RES_WORDS - 1) : 5'(TILE_WORDS - 1);

    // Next-state, counter, command capture and load write-through to the tile registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        base_d      = base_q;
        stride_d    = stride_q;
        tile_wr_d   = 1'b0;
        tile_idx_d  = tile_idx_q;
        tile_data_d = tile_data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    base_d   = base_addr_i;
                    stride_d = stride_i;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    cnt_d = cnt_q + 5'd1;
                    if (!mode_q) begin
                        tile_wr_d   = 1'b1;
                        tile_idx_d  = cnt_q[3:0];
                        tile_data_d = data_rdata_i;
                    end
                    state_d = (cnt_q == last_idx) ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            base_q      <= '0;
            stride_q    <= '0;
            tile_wr_q   <= 1'b0;
            tile_idx_q  <= '0;
            tile_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            tile_wr_q   <= tile_wr_d;
            tile_idx_q  <= tile_idx_d;
            tile_data_q <= tile_data_d;
        end
    end

    riscv_conv_addr_gen u_addr_gen (
        .mode_i   (mode_q),
        .base_i   (base_q),
        .stride_i (stride_q),
        .cnt_i    (cnt_q),
        .addr_o   (data_addr_o)
    );

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign data_req_o   = (state_q == REQ);
    // Write enable and store data only carry meaning while a store command is active
    assign data_we_o    = mode_q && busy_o;
    assign data_wdata_o = (mode_q && busy_o) ? res_data_i : 32'h0;
    assign data_be_o    = 4'b1111;
    assign res_idx_o    = cnt_q[1:0];
    assign tile_wr_o    = tile_wr_q;
    assign tile_idx_o   = tile_idx_q;
    assign tile_data_o  = tile_data_q;

endmodule
